// File: rtl/vec_csr_ctrl.sv
// Vector configuration controller: executes vsetvli/vsetivli/vsetvl, tracks vl/vtype
// and returns the new vl to the scalar core once the vector datapath has drained.
module vec_csr_ctrl #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_valid_i,
    output logic                      inst_ready_o,
    input  logic [XLEN-1:0]           vec_inst_i,
    input  logic [XLEN-1:0]           rs1_i,
    input  logic [XLEN-1:0]           rs2_i,
    input  logic                      vec_busy_i,
    output logic                      rd_wr_en_o,
    output logic [4:0]                rd_addr_o,
    output logic [XLEN-1:0]           rd_data_o,
    output logic [$clog2(VLEN):0]     vl_o,
    output logic [XLEN-1:0]           vtype_o,
    output logic                      cfg_update_o,
    output logic                      err_o
);
    localparam int VW      = $clog2(VLEN) + 1;
    localparam int VTW     = XLEN - 1;
    localparam int CW      = (XLEN > VW) ? XLEN : VW;
    localparam int SEW_MAX = $clog2(ELEN / 8);

    typedef enum logic [1:0] {IDLE, DRAIN, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [16:0]     hi_q;      // instruction bits [31:15]
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_q;
    logic [VTW-1:0]  rs2_q;     // vtype[XLEN-1] is never consumed
    logic [VW-1:0]   vl_q, vl_d;
    logic [XLEN-1:0] vtype_q, vtype_d;
    logic            err_q;

    logic            is_cfg, handshake;
    logic [VTW-1:0]  vt;
    logic [2:0]      vsew, vlmul;
    logic [VW-1:0]   base, vlmax, vl_new;
    logic [XLEN-1:0] avl;
    logic            illegal;

    // Config = OP-V/funct3=111 and one of the three recognised encodings in [31:25].
    assign is_cfg = (vec_inst_i[6:0] == 7'h57) && (vec_inst_i[14:12] == 3'b111) &&
                    (!vec_inst_i[31] || vec_inst_i[30] || (vec_inst_i[31:25] == 7'b1000000));
    assign inst_ready_o = (state_q == IDLE) && !rst;
    assign handshake    = inst_valid_i && inst_ready_o;

    always_comb begin
        if (!hi_q[16])
            vt = VTW'(hi_q[15:5]);
        else if (hi_q[15])
            vt = VTW'(hi_q[14:5]);
        else
            vt = rs2_q;
        vsew  = vt[5:3];
        vlmul = vt[2:0];
        base  = VW'(VLEN) >> (4'd3 + {1'b0, vsew});
        if (!vlmul[2])
            vlmax = base << vlmul;
        else
            vlmax = base >> (4'd8 - {1'b0, vlmul});

        if (hi_q[16] && hi_q[15])
            avl = XLEN'(hi_q[4:0]);
        else if (hi_q[4:0] != 5'd0)
            avl = rs1_q;
        else if (rd_q != 5'd0)
            avl = XLEN'(vlmax);
        else
            avl = XLEN'(vl_q);

        illegal = (32'(vsew) > SEW_MAX) || (vlmul == 3'b100) ||
                  (|vt[VTW-1:8]) || (vlmax == '0);
        // Full-width compare so large AVLs saturate instead of wrapping.
        vl_new  = (CW'(avl) < CW'(vlmax)) ? VW'(avl) : vlmax;
        vl_d    = illegal ? '0 : vl_new;
        vtype_d = illegal ? {1'b1, {VTW{1'b0}}} : {1'b0, vt};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake && is_cfg) state_d = DRAIN;
            DRAIN:   if (!vec_busy_i) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            vl_q    <= '0;
            vtype_q <= {1'b1, {VTW{1'b0}}};
            err_q   <= 1'b0;
        end else begin
            err_q <= handshake && !is_cfg;
            if (handshake && is_cfg) begin
                hi_q  <= vec_inst_i[31:15];
                rd_q  <= vec_inst_i[11:7];
                rs1_q <= rs1_i;
                rs2_q <= rs2_i[VTW-1:0];
            end
            if (state_q == EXEC) begin
                vl_q    <= vl_d;
                vtype_q <= vtype_d;
            end
        end
    end

    assign cfg_update_o = (state_q == RESP);
    assign rd_wr_en_o   = (state_q == RESP) && (rd_q != 5'd0);
    assign rd_addr_o    = (state_q == RESP) ? rd_q : 5'd0;
    assign rd_data_o    = (state_q == RESP) ? XLEN'(vl_q) : '0;
    assign vl_o         = vl_q;
    assign vtype_o      = vtype_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_vec_csr_ctrl.sv
// Scoreboard bench for vec_csr_ctrl: expected results queued at issue, checked on
// cfg_update_o / err_o pulses; latency and ready behaviour checked by the driver.
module tb_vec_csr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] vec_inst_i, rs1_i, rs2_i;
    logic        vec_busy_i;
    logic        rd_wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [9:0]  vl_o;
    logic [31:0] vtype_o;
    logic        cfg_update_o;
    logic        err_o;

    vec_csr_ctrl #(.XLEN(32), .VLEN(512), .ELEN(32)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .vec_inst_i(vec_inst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .vec_busy_i(vec_busy_i),
        .rd_wr_en_o(rd_wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .vl_o(vl_o), .vtype_o(vtype_o),
        .cfg_update_o(cfg_update_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] vl;
        logic [31:0] vt;
        logic        wr;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] vli(input logic [4:0] rd, input logic [4:0] rs1f,
                                        input logic [10:0] vt);
        return {1'b0, vt, rs1f, 3'b111, rd, 7'h57};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cfg_update_o || err_o) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {30'd0, cfg_update_o, err_o}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_kind", {30'd0, cfg_update_o, err_o}, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    chk("vl", 32'(vl_o), e.vl);
                    chk("vtype", vtype_o, e.vt);
                    chk("rd_wr_en", 32'(rd_wr_en_o), 32'(e.wr));
                    if (e.wr) begin
                        chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
                        chk("rd_data", rd_data_o, e.vl);
                    end
                end
            end
        end
    end

    task automatic issue(input string tag, input logic [31:0] inst, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int busy, input logic [31:0] evl,
                         input logic [31:0] evt, input logic [4:0] erd);
        exp_t e;
        int   lat;
        bit   seen, rdy_early;
        e.is_err = 1'b0; e.vl = evl; e.vt = evt; e.rd = erd; e.wr = (erd != 5'd0);
        lat = 0; seen = 1'b0; rdy_early = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_in"}, 32'(inst_ready_o), 32'd1);
        vec_inst_i = inst; rs1_i = rs1; rs2_i = rs2;
        inst_valid_i = 1'b1; vec_busy_i = (busy > 0);
        q.push_back(e);
        @(posedge clk);
        #1 inst_valid_i = 1'b0;
        while (!seen && lat < busy + 12) begin
            @(negedge clk);
            lat++;
            if (cfg_update_o) seen = 1'b1;
            else if (inst_ready_o) rdy_early = 1'b1;
            vec_busy_i = (lat <= busy);
        end
        vec_busy_i = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(3 + busy));
        chk({tag, "_ready_early"}, 32'(rdy_early), 32'd0);
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(inst_ready_o), 32'd1);
    endtask

    task automatic bad_inst(input string tag, input logic [31:0] inst,
                            input logic [31:0] evl, input logic [31:0] evt);
        exp_t e;
        e.is_err = 1'b1; e.vl = '0; e.vt = '0; e.wr = 1'b0; e.rd = '0;
        @(negedge clk);
        vec_inst_i = inst; inst_valid_i = 1'b1; vec_busy_i = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1 inst_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, 32'(err_o), 32'd1);
        chk({tag, "_ready"}, 32'(inst_ready_o), 32'd1);
        chk({tag, "_vl"}, 32'(vl_o), evl);
        chk({tag, "_vtype"}, vtype_o, evt);
        @(negedge clk);
        chk({tag, "_err_once"}, 32'(err_o), 32'd0);
        vec_busy_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_valid_i = 1'b0; vec_inst_i = '0;
        rs1_i = '0; rs2_i = '0; vec_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(inst_ready_o), 32'd0);
        chk("rst_vl", 32'(vl_o), 32'd0);
        chk("rst_vtype", vtype_o, 32'h8000_0000);
        chk("rst_outs", {25'd0, rd_wr_en_o, cfg_update_o, err_o, rd_addr_o[3:0]}, 32'd0);
        chk("rst_rd", {27'd0, rd_addr_o} | rd_data_o, 32'd0);
        rst = 1'b0;

        issue("vli_15",   32'h0101_70D7, 32'd15, 32'd0, 0, 32'd15, 32'h10, 5'd1);
        issue("vli_100",  32'h0101_70D7, 32'd100, 32'd0, 0, 32'd16, 32'h10, 5'd1);
        issue("vsetivli", 32'hC108_7157, 32'd0, 32'd0, 0, 32'd16, 32'h10, 5'd2);
        issue("e8m8",     vli(5'd1, 5'd2, 11'h003), 32'hFFFF_FFFF, 32'd0, 0, 32'd512, 32'h03, 5'd1);
        issue("vsetvl",   32'h8030_F157, 32'h0F, 32'h10, 0, 32'd15, 32'h10, 5'd2);
        issue("vsetvl_e64", 32'h8030_F157, 32'h0F, 32'h18, 0, 32'd0, 32'h8000_0000, 5'd2);
        bad_inst("add", 32'h0000_0033, 32'd0, 32'h8000_0000);
        bad_inst("bad_form", 32'h8230_F157, 32'd0, 32'h8000_0000);
        issue("busy5",    32'h0101_70D7, 32'd15, 32'd0, 5, 32'd15, 32'h10, 5'd1);
        issue("keep_vl",  vli(5'd0, 5'd0, 11'h010), 32'd99, 32'd0, 0, 32'd15, 32'h10, 5'd0);
        issue("mf2",      vli(5'd3, 5'd2, 11'h007), 32'd100, 32'd0, 0, 32'd32, 32'h07, 5'd3);
        issue("lmul_rsv", vli(5'd4, 5'd2, 11'h004), 32'd10, 32'd0, 0, 32'd0, 32'h8000_0000, 5'd4);
        issue("hi_bit",   vli(5'd5, 5'd2, 11'h100), 32'd10, 32'd0, 0, 32'd0, 32'h8000_0000, 5'd5);
        issue("vlmax_m2", vli(5'd6, 5'd0, 11'h00A), 32'd7, 32'd0, 0, 32'd128, 32'h0A, 5'd6);
        issue("avl_wide", vli(5'd7, 5'd2, 11'h010), 32'h8000_0005, 32'd0, 0, 32'd16, 32'h10, 5'd7);
        issue("avl_400",  vli(5'd7, 5'd2, 11'h010), 32'h0000_0400, 32'd0, 2, 32'd16, 32'h10, 5'd7);
        issue("vtype_b31", 32'h8030_F157, 32'h0F, 32'h8000_0010, 0, 32'd15, 32'h10, 5'd2);

        // Abandon an instruction parked in DRAIN.
        @(negedge clk);
        vec_inst_i = 32'h0101_70D7; rs1_i = 32'd3; inst_valid_i = 1'b1; vec_busy_i = 1'b1;
        @(posedge clk);
        #1 inst_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_ready", 32'(inst_ready_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(inst_ready_o), 32'd0);
        chk("rst_mid_vl", 32'(vl_o), 32'd0);
        chk("rst_mid_vtype", vtype_o, 32'h8000_0000);
        chk("rst_mid_wr", 32'(rd_wr_en_o), 32'd0);
        rst = 1'b0; vec_busy_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", 32'(inst_ready_o), 32'd1);

        issue("vl_zero_keep", vli(5'd0, 5'd0, 11'h010), 32'd9, 32'd0, 0, 32'd0, 32'h10, 5'd0);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
